// File: rtl/cpu_param.sv
// cpu_param: small multi-cycle accumulator-less CPU with an 8-entry register
// file, a two-word instruction format and a ready/valid style memory port.
// Every instruction goes FETCHA -> FETCHB -> EXECA -> EXECB; memory stages
// stall on mem_ready. Define CPU_PARAM_SHIFT_EN to enable the SHL/SHR unit
// (G=101); without it G=101 executes as NOP.
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic              mem_ready,
    output logic              waits,
    output logic              fetcha,
    output logic              fetchb,
    output logic              execa,
    output logic              execb,
    output logic [ADDR_W-1:0] pc_out,
    output logic              cflag,
    output logic              zflag
);

    typedef enum logic [2:0] {
        S_WAITS  = 3'd0,
        S_FETCHA = 3'd1,
        S_FETCHB = 3'd2,
        S_EXECA  = 3'd3,
        S_EXECB  = 3'd4
    } stage_t;

    stage_t            r_stage;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_op;
    logic [DATA_W-1:0] r_opr;
    logic [DATA_W-1:0] r_ld;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [8];
    logic              r_rden;
    logic              r_wren;
    logic              r_c;
    logic              r_z;
    logic              r_halt_req;

    // Instruction fields
    logic [2:0]        w_g;
    logic [1:0]        w_f;
    logic [2:0]        w_r;
    logic [2:0]        w_a;
    logic [2:0]        w_b;
    logic [ADDR_W-1:0] w_k;
    logic [ADDR_W-1:0] w_k_fetch;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_hlt;
    logic              w_jmp_taken;

    assign w_g       = r_op[7:5];
    assign w_f       = r_op[4:3];
    assign w_r       = r_op[2:0];
    assign w_a       = r_opr[5:3];
    assign w_b       = r_opr[2:0];
    assign w_k       = r_opr[ADDR_W-1:0];
    // Operand word arriving at the end of FETCHB: its K sets up the EXECA access
    assign w_k_fetch = mem_rdata[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_is_ld   = (w_g == 3'b000) && (w_f == 2'b01);
    assign w_is_st   = (w_g == 3'b000) && (w_f == 2'b10);
    assign w_is_hlt  = (w_g == 3'b000) && (w_f == 2'b11);

    // ALU operands and wide results (MSB is carry / borrow)
    logic [DATA_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rb;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;

    assign w_ra  = r_regs[w_a];
    assign w_rb  = r_regs[w_b];
    assign w_add = {1'b0, w_ra} + {1'b0, w_rb};
    assign w_sub = {1'b0, w_ra} - {1'b0, w_rb};

`ifdef CPU_PARAM_SHIFT_EN
    logic [DATA_W-1:0] w_rr;
    assign w_rr = r_regs[w_r];
`endif

    // Conditional jump evaluation against the current flags
    always_comb begin
        w_jmp_taken = 1'b0;
        case (w_f)
            2'b00:   w_jmp_taken = r_c;
            2'b01:   w_jmp_taken = r_z;
            2'b10:   w_jmp_taken = ~r_z;
            default: w_jmp_taken = 1'b1;
        endcase
    end

    // Write-back value, write enable and flag update for EXECB
    logic [DATA_W-1:0] w_res;
    logic              w_wb_en;
    logic              w_flag_en;
    logic              w_c_next;

    always_comb begin
        w_res     = '0;
        w_wb_en   = 1'b0;
        w_flag_en = 1'b0;
        w_c_next  = r_c;
        case (w_g)
            3'b000: begin
                if (w_is_ld) begin
                    w_wb_en = 1'b1;
                    w_res   = r_ld;
                end
            end
            3'b010: begin
                w_wb_en = 1'b1;
                w_res   = DATA_W'(w_k);
            end
            3'b100: begin
                w_wb_en   = 1'b1;
                w_flag_en = 1'b1;
                case (w_f)
                    2'b00: begin
                        w_res    = w_add[DATA_W-1:0];
                        w_c_next = w_add[DATA_W];
                    end
                    2'b01: begin
                        w_res    = w_sub[DATA_W-1:0];
                        w_c_next = w_sub[DATA_W];
                    end
                    2'b10: begin
                        w_res    = w_ra & w_rb;
                        w_c_next = 1'b0;
                    end
                    default: begin
                        w_res    = w_ra | w_rb;
                        w_c_next = 1'b0;
                    end
                endcase
            end
`ifdef CPU_PARAM_SHIFT_EN
            3'b101: begin
                if (w_f == 2'b00) begin
                    w_wb_en   = 1'b1;
                    w_flag_en = 1'b1;
                    w_res     = {w_rr[DATA_W-2:0], 1'b0};
                    w_c_next  = w_rr[DATA_W-1];
                end else if (w_f == 2'b01) begin
                    w_wb_en   = 1'b1;
                    w_flag_en = 1'b1;
                    w_res     = {1'b0, w_rr[DATA_W-1:1]};
                    w_c_next  = w_rr[0];
                end
            end
`endif
            default: ;
        endcase
    end

    // Stage sequencing with registered memory strobes/address, PC, registers and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage    <= S_WAITS;
            r_pc       <= '0;
            r_addr     <= '0;
            r_op       <= '0;
            r_opr      <= '0;
            r_ld       <= '0;
            r_wdata    <= '0;
            r_rden     <= 1'b0;
            r_wren     <= 1'b0;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_halt_req <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (halt && (r_stage != S_WAITS)) begin
                r_halt_req <= 1'b1;
            end
            case (r_stage)
                S_WAITS: begin
                    if (run) begin
                        r_stage <= S_FETCHA;
                        r_rden  <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                S_FETCHA: begin
                    if (mem_ready) begin
                        r_op    <= mem_rdata;
                        r_pc    <= w_pc_inc;
                        r_addr  <= w_pc_inc;
                        r_stage <= S_FETCHB;
                    end
                end
                S_FETCHB: begin
                    if (mem_ready) begin
                        r_opr   <= mem_rdata;
                        r_pc    <= w_pc_inc;
                        r_stage <= S_EXECA;
                        // Strobes for EXECA are set up here so they are registered on entry
                        if (w_is_ld) begin
                            r_addr <= w_k_fetch;
                        end else if (w_is_st) begin
                            r_rden  <= 1'b0;
                            r_wren  <= 1'b1;
                            r_addr  <= w_k_fetch;
                            r_wdata <= r_regs[w_r];
                        end else begin
                            r_rden <= 1'b0;
                            r_addr <= w_pc_inc;
                        end
                    end
                end
                S_EXECA: begin
                    if (!(r_rden || r_wren) || mem_ready) begin
                        if (r_rden) begin
                            r_ld <= mem_rdata;
                        end
                        r_rden  <= 1'b0;
                        r_wren  <= 1'b0;
                        r_stage <= S_EXECB;
                        if ((w_g == 3'b001) && w_jmp_taken) begin
                            r_pc   <= w_k;
                            r_addr <= w_k;
                        end else begin
                            r_addr <= r_pc;
                        end
                    end
                end
                S_EXECB: begin
                    if (w_wb_en) begin
                        r_regs[w_r] <= w_res;
                    end
                    if (w_flag_en) begin
                        r_c <= w_c_next;
                        r_z <= (w_res == '0);
                    end
                    r_halt_req <= 1'b0;
                    r_addr     <= r_pc;
                    if (halt || r_halt_req || w_is_hlt) begin
                        r_stage <= S_WAITS;
                    end else begin
                        r_stage <= S_FETCHA;
                        r_rden  <= 1'b1;
                    end
                end
                default: r_stage <= S_WAITS;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_rden  = r_rden;
    assign mem_wren  = r_wren;
    assign waits     = (r_stage == S_WAITS);
    assign fetcha    = (r_stage == S_FETCHA);
    assign fetchb    = (r_stage == S_FETCHB);
    assign execa     = (r_stage == S_EXECA);
    assign execb     = (r_stage == S_EXECB);
    assign pc_out    = r_pc;
    assign cflag     = r_c;
    assign zflag     = r_z;

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: bench for cpu_param with an instruction-level reference model.
// The model executes one whole instruction from its own memory image at each
// instruction boundary and is compared against pc/flags/stage; bus protocol
// is checked every cycle. Shift expectations follow CPU_PARAM_SHIFT_EN.
module tb_cpu_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       halt;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_rden;
    logic       mem_wren;
    logic       mem_ready;
    logic       waits, fetcha, fetchb, execa, execb;
    logic [7:0] pc_out;
    logic       cflag, zflag;
    logic [4:0] stage;

    localparam logic [4:0] ST_W  = 5'b10000;
    localparam logic [4:0] ST_FA = 5'b01000;
    localparam logic [4:0] ST_FB = 5'b00100;
    localparam logic [4:0] ST_EA = 5'b00010;
    localparam logic [4:0] ST_EB = 5'b00001;

    cpu_param #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_ready (mem_ready),
        .waits     (waits),
        .fetcha    (fetcha),
        .fetchb    (fetchb),
        .execa     (execa),
        .execb     (execb),
        .pc_out    (pc_out),
        .cflag     (cflag),
        .zflag     (zflag)
    );

    always #5 clk = ~clk;

    assign stage = {waits, fetcha, fetchb, execa, execb};

    // Bench memory (driven to the DUT) and the model's own memory image
    logic [7:0] mem [256];
    logic [7:0] mm  [256];
    // Model architectural state
    logic [7:0] mr  [8];
    logic [7:0] mpc;
    logic       mc, mz;
    logic       halt_seen;

    // Data is only meaningful while ready; otherwise present garbage
    assign mem_rdata = mem_ready ? mem[mem_addr] : ~mem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        mm[a]  = d;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] op, input logic [7:0] opr);
        poke(a, op);
        poke(a + 8'd1, opr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 8'h00;
        mpc       = 8'h00;
        mc        = 1'b0;
        mz        = 1'b0;
        halt_seen = 1'b0;
    endtask

    // Execute one full instruction at the architectural level
    task automatic iss_step(output logic stop);
        logic [7:0] op, opr, x, y;
        logic [2:0] g, r, a, b;
        logic [1:0] f;
        int         s, res;
        logic       taken;
        op  = mm[mpc];
        opr = mm[mpc + 8'd1];
        mpc = mpc + 8'd2;
        g = op[7:5]; f = op[4:3]; r = op[2:0];
        a = opr[5:3]; b = opr[2:0];
        stop = 1'b0;
        case (g)
            3'd0: begin
                if (f == 2'd1) mr[r] = mm[opr];
                else if (f == 2'd2) mm[opr] = mr[r];
                else if (f == 2'd3) stop = 1'b1;
            end
            3'd1: begin
                taken = (f == 2'd0) ? mc : (f == 2'd1) ? mz : (f == 2'd2) ? !mz : 1'b1;
                if (taken) mpc = opr;
            end
            3'd2: mr[r] = opr;
            3'd4: begin
                x = mr[a];
                y = mr[b];
                case (f)
                    2'd0: begin s = int'(x) + int'(y); mc = (s > 255); res = s % 256; end
                    2'd1: begin mc = (x < y); res = (int'(x) - int'(y) + 256) % 256; end
                    2'd2: begin res = int'(x & y); mc = 1'b0; end
                    default: begin res = int'(x | y); mc = 1'b0; end
                endcase
                mz = (res == 0);
                mr[r] = 8'(res);
            end
`ifdef CPU_PARAM_SHIFT_EN
            3'd5: begin
                if (f == 2'd0) begin
                    s = int'(mr[r]) * 2;
                    mc = (s > 255); res = s % 256;
                    mz = (res == 0); mr[r] = 8'(res);
                end else if (f == 2'd1) begin
                    mc = mr[r][0]; res = int'(mr[r]) / 2;
                    mz = (res == 0); mr[r] = 8'(res);
                end
            end
`endif
            default: ;
        endcase
    endtask

    // One clock: sample pre-edge inputs, advance, update memory and run checks
    task automatic cycle();
        logic       p_rst, p_halt, p_ready, p_rden, p_wren, stop;
        logic [7:0] p_addr, p_wdata;
        logic [4:0] p_stage;
        p_rst = rst; p_halt = halt; p_ready = mem_ready;
        p_rden = mem_rden; p_wren = mem_wren;
        p_addr = mem_addr; p_wdata = mem_wdata; p_stage = stage;
        @(posedge clk);
        #1;
        if (!p_rst && p_wren && p_ready) mem[p_addr] = p_wdata;
        if (p_rst) begin
            model_reset();
        end else begin
            if ((p_stage != ST_W) && p_halt) halt_seen = 1'b1;
            if (p_stage == ST_EB) begin
                iss_step(stop);
                stop = stop | halt_seen;
                halt_seen = 1'b0;
                check_eq("pc", pc_out, mpc);
                check_eq("cflag", cflag, mc);
                check_eq("zflag", zflag, mz);
                check_eq("next_stage", stage, stop ? ST_W : ST_FA);
            end
            if ((p_rden || p_wren) && !p_ready) begin
                check_eq("hold_bus", {mem_addr, mem_wdata, mem_rden, mem_wren},
                         {p_addr, p_wdata, p_rden, p_wren});
                check_eq("hold_stage", stage, p_stage);
            end
        end
        check_eq("onehot", $onehot(stage), 1);
        check_eq("strobe_excl", mem_rden & mem_wren, 0);
        if (waits) check_eq("waits_idle", {mem_rden, mem_wren}, 0);
    endtask

    task automatic wait_for(input logic [4:0] mask, input int budget, input string tag);
        int n = 0;
        while (((stage & mask) == 5'b0) && (n < budget)) begin
            cycle();
            n++;
        end
        check_eq(tag, ((stage & mask) != 5'b0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        cycle();
        run = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; halt = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        check_eq("rst_stage", stage, ST_W);
        check_eq("rst_pc", pc_out, 0);
        check_eq("rst_flags", {cflag, zflag}, 0);
        check_eq("rst_bus", {mem_addr, mem_rden, mem_wren}, 0);
        cycle();
        check_eq("idle_stage", stage, ST_W);

        // LDI/LDI/ADD overflow to zero, 4 cycles per instruction
        prog(8'h00, 8'h41, 8'hFF);
        prog(8'h02, 8'h42, 8'h01);
        prog(8'h04, 8'h83, 8'h0A);
        prog(8'h06, 8'h13, 8'h90);
        prog(8'h08, 8'h18, 8'h00);
        poke(8'h90, 8'hEE);
        start();
        n = 1;
        while (!waits && n < 100) begin
            cycle();
            n++;
        end
        check_eq("add_cycles", n, 21);
        check_eq("add_cflag", cflag, 1);
        check_eq("add_zflag", zflag, 1);
        check_eq("add_r3", mem[8'h90], 8'h00);

        // LD with EXECA stalled 3 cycles
        do_reset();
        prog(8'h00, 8'h08, 8'h20);
        prog(8'h02, 8'h10, 8'h91);
        prog(8'h04, 8'h18, 8'h00);
        poke(8'h20, 8'h5A);
        start();
        wait_for(ST_EA, 20, "ld_reach_execa");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("ld_hold_stage", stage, ST_EA);
            check_eq("ld_hold_addr", {mem_addr, mem_rden}, {8'h20, 1'b1});
        end
        mem_ready = 1'b1;
        cycle();
        check_eq("ld_release", stage, ST_EB);
        wait_for(ST_W, 20, "ld_done");
        check_eq("ld_r0", mem[8'h91], 8'h5A);

        // SUB to zero, JNZ not taken, JZ taken
        do_reset();
        prog(8'h00, 8'h41, 8'h05);
        prog(8'h02, 8'h42, 8'h05);
        prog(8'h04, 8'h8B, 8'h0A);
        prog(8'h06, 8'h30, 8'h40);
        prog(8'h08, 8'h28, 8'h40);
        prog(8'h40, 8'h18, 8'h00);
        start();
        for (int i = 1; i <= 5; i++) begin
            wait_for(ST_EA, 20, "jmp_reach_execa");
            cycle();
            if (i == 4) begin
                check_eq("jnz_pc", pc_out, 8'h08);
                check_eq("sub_flags", {cflag, zflag}, 2'b01);
            end
            if (i == 5) check_eq("jz_pc", pc_out, 8'h40);
        end
        wait_for(ST_W, 20, "jmp_done");
        check_eq("jmp_final_pc", pc_out, 8'h42);

        // halt during FETCHB of a store
        do_reset();
        prog(8'h00, 8'h41, 8'h77);
        prog(8'h02, 8'h11, 8'h10);
        prog(8'h04, 8'h45, 8'h33);
        prog(8'h06, 8'h15, 8'h92);
        prog(8'h08, 8'h18, 8'h00);
        poke(8'h10, 8'h00);
        start();
        wait_for(ST_FB, 20, "halt_fb1");
        cycle();
        wait_for(ST_FB, 20, "halt_fb2");
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        wait_for(ST_W, 20, "halt_stop");
        check_eq("halt_pc", pc_out, 8'h04);
        check_eq("halt_store", mem[8'h10], 8'h77);
        start();
        check_eq("resume_stage", stage, ST_FA);
        check_eq("resume_addr", mem_addr, 8'h04);
        wait_for(ST_W, 40, "resume_done");
        check_eq("resume_store", mem[8'h92], 8'h33);
        check_eq("resume_pc", pc_out, 8'h0A);

        // Reset in the middle of EXECA with ready high
        do_reset();
        prog(8'h00, 8'h41, 8'hFF);
        prog(8'h02, 8'h42, 8'h01);
        prog(8'h04, 8'h83, 8'h0A);
        prog(8'h06, 8'h44, 8'h12);
        prog(8'h08, 8'h18, 8'h00);
        start();
        for (int i = 1; i <= 4; i++) begin
            wait_for(ST_EA, 20, "mid_reach_execa");
            if (i < 4) cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mid_rst_stage", stage, ST_W);
        check_eq("mid_rst_pc", pc_out, 0);
        check_eq("mid_rst_flags", {cflag, zflag}, 0);
        check_eq("mid_rst_bus", {mem_addr, mem_rden, mem_wren}, 0);
        for (int i = 0; i < 8; i++) begin
            prog(8'(2 * i), 8'h10 | 8'(i), 8'hA0 + 8'(i));
            poke(8'hA0 + 8'(i), 8'hEE);
        end
        prog(8'h10, 8'h18, 8'h00);
        start();
        wait_for(ST_W, 100, "dump_done");
        for (int i = 0; i < 8; i++) check_eq($sformatf("mid_rst_r%0d", i), mem[8'hA0 + 8'(i)], 8'h00);

        // Shift right of 0x81
        do_reset();
        prog(8'h00, 8'h88, 8'h00);
        prog(8'h02, 8'h44, 8'h81);
        prog(8'h04, 8'hAC, 8'h00);
        prog(8'h06, 8'h14, 8'h93);
        prog(8'h08, 8'h18, 8'h00);
        start();
        wait_for(ST_W, 40, "shr_done");
`ifdef CPU_PARAM_SHIFT_EN
        check_eq("shr_r4", mem[8'h93], 8'h40);
        check_eq("shr_flags", {cflag, zflag}, 2'b10);
`else
        check_eq("shr_r4", mem[8'h93], 8'h81);
        check_eq("shr_flags", {cflag, zflag}, 2'b01);
`endif

        // Random memory image, random ready/halt/run
        do_reset();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        for (int c = 0; c < 4000; c++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            halt      = ($urandom_range(0, 31) == 0);
            run       = ($urandom_range(0, 3) != 0);
            cycle();
        end
        run = 1'b0;
        halt = 1'b1;
        mem_ready = 1'b1;
        wait_for(ST_W, 20, "rand_stop");
        halt = 1'b0;
        cycle();
        for (int i = 0; i < 256; i++) check_eq($sformatf("mem[%0d]", i), mem[i], mm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
